// File: rtl/test_uart_tx.sv
// Debug tap: queues every change on the processor's 8-bit test bus and
// shifts each queued byte out as an 8N1 UART frame on tx.
module test_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                         CLKSYS,
   input  logic                         RST,
   input  logic [7:0]                   test_in,
   output logic                         tx,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                         overflow
);

   localparam int AddrW = $clog2(FIFO_DEPTH);
   localparam int BaudW = $clog2(CLKS_PER_BIT);
   localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [AddrW:0]   FullCount = (AddrW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [AddrW-1:0]  r_wptr;
   logic [AddrW-1:0]  r_rptr;
   logic [AddrW:0]    r_count;
   logic [7:0]        r_prev;
   logic [7:0]        r_shift;
   logic [BaudW-1:0]  r_baud;
   logic [2:0]        r_bit_idx;
   logic              r_tx;
   logic              r_overflow;

   logic w_push;
   logic w_full;
   logic w_accept;
   logic w_pop;
   logic w_shift;
   logic w_tx_d;
   logic w_bit_done;
   logic w_last_bit;

   assign w_push     = (test_in != r_prev);
   assign w_full     = (r_count == FullCount);
   // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
   assign w_accept   = w_push && (!w_full || w_pop);
   assign w_bit_done = (r_baud == BaudLast);
   assign w_last_bit = (r_bit_idx == 3'd7);

   always_ff @(posedge CLKSYS) begin
      if (RST) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (r_count != '0) w_state_d = StStart;
         StStart: if (w_bit_done) w_state_d = StData;
         StData:  if (w_bit_done && w_last_bit) w_state_d = StStop;
         StStop:  if (w_bit_done) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_pop   = 1'b0;
      w_shift = 1'b0;
      w_tx_d  = r_tx;
      unique case (r_state)
         StIdle: begin
            w_tx_d = 1'b1;
            if (r_count != '0) begin
               w_pop  = 1'b1;
               w_tx_d = 1'b0;
            end
         end
         StStart: begin
            if (w_bit_done) begin
               w_tx_d  = r_shift[0];
               w_shift = 1'b1;
            end
         end
         StData: begin
            if (w_bit_done) begin
               if (w_last_bit) begin
                  w_tx_d = 1'b1;
               end else begin
                  w_tx_d  = r_shift[0];
                  w_shift = 1'b1;
               end
            end
         end
         StStop:  w_tx_d = 1'b1;
         default: w_tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLKSYS) begin
      if (!RST && w_accept) begin
         r_mem[r_wptr] <= test_in;
      end
   end

   always_ff @(posedge CLKSYS) begin
      if (RST) begin
         r_tx       <= 1'b1;
         r_prev     <= 8'h00;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_shift    <= 8'h00;
         r_baud     <= '0;
         r_bit_idx  <= '0;
      end else begin
         r_tx   <= w_tx_d;
         r_prev <= test_in;
         if (w_accept) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_accept) r_overflow <= 1'b1;
         if (w_accept && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_accept && w_pop) begin
            r_count <= r_count - 1'b1;
         end
         // Shift right so bit 0 always holds the next data bit to drive.
         if (w_pop) begin
            r_shift <= r_mem[r_rptr];
         end else if (w_shift) begin
            r_shift <= {1'b0, r_shift[7:1]};
         end
         if (r_state == StIdle || w_bit_done) begin
            r_baud <= '0;
         end else begin
            r_baud <= r_baud + 1'b1;
         end
         if (r_state != StData) begin
            r_bit_idx <= '0;
         end else if (w_bit_done) begin
            r_bit_idx <= r_bit_idx + 1'b1;
         end
      end
   end

   assign tx         = r_tx;
   assign busy       = (r_state != StIdle);
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_test_uart_tx.sv
// Bench for test_uart_tx: queue/timing model checked every cycle, a UART
// receiver decoding tx, and directed scenarios with hand-computed values.
module tb_test_uart_tx;

   localparam int Cpb   = 16;
   localparam int Depth = 4;

   logic       CLKSYS = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] test_in = 8'h00;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;

   test_uart_tx #(
      .CLKS_PER_BIT(Cpb),
      .FIFO_DEPTH  (Depth)
   ) u_dut (
      .CLKSYS    (CLKSYS),
      .RST       (RST),
      .test_in   (test_in),
      .tx        (tx),
      .busy      (busy),
      .fifo_count(fifo_count),
      .overflow  (overflow)
   );

   always #5 CLKSYS = ~CLKSYS;

   int cyc = 0;
   always @(posedge CLKSYS) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a byte queue plus the elapsed time of the frame on the line.
   logic [7:0] m_q[$];
   logic [7:0] m_prev = 8'h00;
   logic [7:0] m_byte = 8'h00;
   int         m_phase = -1;
   bit         m_ovf = 1'b0;
   bit         m_valid = 1'b0;
   bit         m_rst_edge = 1'b0;
   bit         m_pop;
   bit         m_push;

   always @(posedge CLKSYS) begin
      m_rst_edge = RST;
      if (RST) begin
         m_q.delete();
         m_prev  = 8'h00;
         m_phase = -1;
         m_ovf   = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_pop  = (m_phase < 0) && (m_q.size() > 0);
         m_push = (test_in != m_prev);
         m_prev = test_in;
         if (m_phase >= 0) begin
            m_phase++;
            if (m_phase == 10 * Cpb) m_phase = -1;
         end
         if (m_push && m_q.size() == Depth && !m_pop) begin
            m_ovf  = 1'b1;
            m_push = 1'b0;
         end
         if (m_pop) begin
            m_byte  = m_q.pop_front();
            m_phase = 0;
         end
         if (m_push) m_q.push_back(test_in);
      end
   end

   function automatic logic exp_tx();
      int slot;
      if (m_phase < 0) return 1'b1;
      slot = m_phase / Cpb;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return m_byte[slot-1];
   endfunction

   always @(negedge CLKSYS) begin
      if (m_valid) begin
         chk("tx", 32'(tx), 32'(exp_tx()));
         chk("busy", 32'(busy), 32'(m_phase >= 0));
         chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   // Receiver: samples mid-bit, logs byte and the edge where the start bit began.
   logic [7:0] rx_data[$];
   int         rx_cyc[$];
   int         rx_t = -1;
   int         rx_start = 0;
   logic [7:0] rx_byte = 8'h00;
   logic       tx_prev = 1'b1;

   always @(negedge CLKSYS) begin
      if (m_rst_edge) begin
         rx_t = -1;
      end else if (rx_t < 0) begin
         if (tx_prev && !tx) begin
            rx_t     = 0;
            rx_start = cyc;
         end
      end else begin
         rx_t++;
         if (rx_t % Cpb == Cpb / 2 && rx_t / Cpb >= 1 && rx_t / Cpb <= 8) begin
            rx_byte[rx_t/Cpb-1] = tx;
         end
         if (rx_t == 9 * Cpb + Cpb / 2) begin
            rx_data.push_back(rx_byte);
            rx_cyc.push_back(rx_start);
            rx_t = -1;
         end
      end
      tx_prev = tx;
   end

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge CLKSYS);
   endtask

   task automatic wait_rx(input int n, input int budget);
      int b = budget;
      while (rx_data.size() < n && b > 0) begin
         @(negedge CLKSYS);
         b--;
      end
   endtask

   task automatic rx_clear();
      rx_data.delete();
      rx_cyc.delete();
   endtask

   initial begin
      int         k;
      int         s;
      int         p;
      int         max_cnt;
      bit         saw_low;
      logic [7:0] a5;
      int         exp_cnt[5] = '{1, 2, 3, 4, 4};

      RST = 1'b1;
      @(negedge CLKSYS);
      @(negedge CLKSYS);
      RST = 1'b0;
      @(negedge CLKSYS);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_count", 32'(fifo_count), 32'd0);

      // Single byte A5
      a5 = 8'hA5;
      test_in = 8'hA5;
      @(negedge CLKSYS);
      k = cyc;
      chk("t1_count_after_push", 32'(fifo_count), 32'd1);
      chk("t1_tx_idle_at_push", 32'(tx), 32'd1);
      @(negedge CLKSYS);
      chk("t1_start_bit", 32'(tx), 32'd0);
      chk("t1_busy_rise", 32'(busy), 32'd1);
      chk("t1_count_after_pop", 32'(fifo_count), 32'd0);
      for (int i = 0; i < 8; i++) begin
         wait_to(k + 1 + Cpb * (i + 1) + Cpb / 2);
         chk("t1_data_bit", 32'(tx), 32'(a5[i]));
      end
      wait_to(k + 160);
      chk("t1_busy_before_end", 32'(busy), 32'd1);
      wait_to(k + 161);
      chk("t1_busy_fall", 32'(busy), 32'd0);
      chk("t1_overflow", 32'(overflow), 32'd0);
      chk("t1_rx_frames", 32'(rx_data.size()), 32'd1);
      if (rx_data.size() > 0) chk("t1_rx_byte", 32'(rx_data[0]), 32'hA5);

      // Steady bus
      rx_clear();
      test_in = 8'h3C;
      max_cnt = 0;
      repeat (500) begin
         @(negedge CLKSYS);
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      end
      chk("t2_max_count", 32'(max_cnt), 32'd1);
      chk("t2_rx_frames", 32'(rx_data.size()), 32'd1);
      if (rx_data.size() > 0) chk("t2_rx_byte", 32'(rx_data[0]), 32'h3C);

      // Burst and overflow
      rx_clear();
      test_in = 8'h01;
      @(negedge CLKSYS);
      @(negedge CLKSYS);
      for (int v = 2; v <= 6; v++) begin
         test_in = 8'(v);
         @(negedge CLKSYS);
         chk("t3_count", 32'(fifo_count), 32'(exp_cnt[v-2]));
         chk("t3_overflow", 32'(overflow), 32'(v == 6));
      end
      wait_rx(5, 1200);
      chk("t3_rx_frames", 32'(rx_data.size()), 32'd5);
      for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
         chk("t3_rx_byte", 32'(rx_data[i]), 32'(i + 1));
         if (i > 0) chk("t3_spacing", 32'(rx_cyc[i] - rx_cyc[i-1]), 32'd161);
      end
      chk("t3_overflow_sticky", 32'(overflow), 32'd1);
      repeat (20) @(negedge CLKSYS);

      // Full FIFO with a push landing on the pop edge
      RST = 1'b1;
      test_in = 8'h00;
      @(negedge CLKSYS);
      @(negedge CLKSYS);
      RST = 1'b0;
      rx_clear();
      test_in = 8'h10;
      @(negedge CLKSYS);
      s = cyc;
      p = s + 1;
      for (int v = 8'h11; v <= 8'h14; v++) begin
         test_in = 8'(v);
         @(negedge CLKSYS);
      end
      wait_to(p + 160);
      chk("t4_full_before", 32'(fifo_count), 32'd4);
      chk("t4_idle_gap", 32'(busy), 32'd0);
      test_in = 8'h15;
      @(negedge CLKSYS);
      chk("t4_count_kept", 32'(fifo_count), 32'd4);
      chk("t4_no_overflow", 32'(overflow), 32'd0);
      chk("t4_next_start", 32'(tx), 32'd0);
      wait_rx(6, 1500);
      chk("t4_rx_frames", 32'(rx_data.size()), 32'd6);
      for (int i = 0; i < 6 && i < rx_data.size(); i++) begin
         chk("t4_rx_byte", 32'(rx_data[i]), 32'(8'h10 + i));
      end
      chk("t4_overflow_end", 32'(overflow), 32'd0);
      repeat (20) @(negedge CLKSYS);

      // Reset during data bit 3 with two bytes queued
      rx_clear();
      test_in = 8'h20;
      @(negedge CLKSYS);
      s = cyc;
      p = s + 1;
      test_in = 8'h21;
      @(negedge CLKSYS);
      test_in = 8'h22;
      @(negedge CLKSYS);
      chk("t5_queued", 32'(fifo_count), 32'd2);
      wait_to(p + 70);
      chk("t5_mid_frame", 32'(busy), 32'd1);
      RST = 1'b1;
      test_in = 8'h00;
      @(negedge CLKSYS);
      chk("t5_tx", 32'(tx), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_count", 32'(fifo_count), 32'd0);
      chk("t5_overflow", 32'(overflow), 32'd0);
      RST = 1'b0;
      rx_clear();
      saw_low = 1'b0;
      repeat (400) begin
         @(negedge CLKSYS);
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      chk("t5_line_quiet", 32'(saw_low), 32'd0);
      chk("t5_rx_frames", 32'(rx_data.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
